ipg_multi_ch_inserter: RTL and testbench
========================================

Name: ipg_multi_ch_inserter

Overview:
- Multi-channel successor to the single-stream IPG shim.
- Sits on the 64b/66b TX path between the PCS encoder output and the serdes TX pipeline.
- Replaces pure idle control blocks with tagged IPG-data blocks drawn from NUM_CH per-channel payload FIFOs.
- Channels are served round-robin, and a programmable number of true idle blocks after each frame is kept.

Parameters:
- NUM_CH, 4, number of payload channels (1..64).
- FIFO_DEPTH, 8, words per channel FIFO (power of two, >=2).
- KEEP_IDLE, 1, idle blocks after each terminate block that pass unmodified before insertion is allowed (0..15).

Ports:
- clk  input  1  block clock.
- rst  input  1  synchronous active-high reset.
- enable  input  1  insertion enable; 0 = pure pass-through (FIFOs still accept).
- in_data  input  64  encoded block from encoder.
- in_hdr  input  2  sync header (2'b01 ctrl, 2'b10 data).
- in_valid  input  1  block valid (gearbox pause when 0).
- out_data  output  64  block to serdes.
- out_hdr  output  2  header to serdes.
- out_valid  output  1  registered in_valid.
- s_payload_data  input  NUM_CH*48  per-channel 48-bit payload; channel c at [48c+47:48c].
- s_payload_valid  input  NUM_CH  per-channel valid.
- s_payload_ready  output  NUM_CH  per-channel ready (FIFO not full).
- insert_count  output  32  total inserted blocks, wraps at 2^32.

Behaviour:
- Reset values: out_data=0, out_hdr=2'b01, out_valid=0, insert_count=0, all FIFOs empty, s_payload_ready all 1, round-robin pointer=0, gap counter=KEEP_IDLE (insertion permitted).
- Latency: exactly 1 cycle, in_* to out_*, whether or not a block is replaced. in_valid=0 cycles propagate with out_valid=0; no insertion and no state change occur on those cycles.
- Idle block: in_hdr==2'b01 && in_data[7:0]==8'h1e && in_data[63:8]==0. A type-0x1e block with nonzero upper bits (error codes or foreign inserted data) is not idle and passes unchanged.
- Terminate block: in_hdr==2'b01 and type in {87,99,aa,b4,cc,d2,e1,ff}. On a valid terminate block the gap counter clears to 0.
- Gap counter: each valid idle block that passes unmodified increments it, saturating at 15.
- Start block: type 33 or 78. It does not alter the counter, because the frame is ended only by a terminate block.
- Insertion condition, checked per valid cycle:
  - enable==1
  - the block is idle
  - gap counter >= KEEP_IDLE
  - at least one FIFO is non-empty
- Replacement block format:
  - out_hdr=2'b01.
  - [7:0]=8'h1e.
  - [55:8]=payload word.
  - [61:56]=channel index.
  - [63:62]=2'b01.
- Inserted blocks do not advance the gap counter.
- Arbitration: round-robin. Search starts at pointer and takes the first non-empty channel. After a grant the pointer moves to granted+1 mod NUM_CH. The pointer is unchanged when nothing is granted.
- FIFO write: when s_payload_valid[c] && s_payload_ready[c], the word is written into FIFO c.
- s_payload_ready[c] = !full[c], registered from occupancy. A simultaneous pop and push on a full FIFO still deasserts ready that cycle; the pop frees space the following cycle.
- Pop and push on the same cycle on a non-empty FIFO both occur, and occupancy is unchanged.
- Empty FIFO: a push on cycle N makes the word eligible for grant on cycle N+1 (no bypass).
- Wrap-around: FIFO pointers use log2(FIFO_DEPTH)+1 bits. Full = MSBs differ and the lower bits are equal.
- insert_count increments by 1 per inserted block.
- enable deassert: takes effect that cycle. Queued words are retained, not dropped.
- Reset mid-operation: FIFO contents are discarded and outputs take their reset values on the next edge. Any block in flight is lost.

Test Plan:
- Pass-through: enable=0, drive data block hdr=10 data=64'h1234 then idle block → out identical 1 cycle later; insert_count=0.
- Single insert, KEEP_IDLE=1:
  - Stimulus: push ch2 word 48'hABCDEF012345; drive terminate 8'h87, then idle, then idle.
  - Response: first idle passes unchanged. Second idle outputs 64'h42ABCDEF0123451e (marker 01, ch 2). insert_count=1.
- Round-robin:
  - Stimulus: push one word each to ch0, ch1 and ch3; drive 4 idles with gap already open.
  - Response: channels emitted in order 0,1,3, then the 4th idle passes unchanged; pointer returns to 0.
- Backpressure:
  - Stimulus: FIFO_DEPTH=8; push 9 words to ch1 with no idles.
  - Response: s_payload_ready[1] drops after the 8th accept; the 9th is held. After one insertion, ready returns the next cycle.
- Non-idle 0x1e: drive hdr=01 data=64'haddaaddaddadda1e → output unchanged, no FIFO pop.
- Reset mid-stream:
  - Stimulus: 3 words queued; assert rst for 1 cycle.
  - Response: all ready=1, insert_count=0, and the following idles pass unchanged.
- Gap pause: drop in_valid for 2 cycles during the gap → out_valid=0 on those cycles; the gap counter and FIFOs are unchanged.

Source files
------------

// File: rtl/ipg_multi_ch_inserter_if.sv
// Block stream and per-channel payload bundle for the multi-channel IPG inserter.
// The master drives encoder blocks and payload; the slave is the inserter itself.
interface ipg_multi_ch_inserter_if #(
   parameter int NUM_CH = 4
);
   logic [63:0]          in_data;
   logic [1:0]           in_hdr;
   logic                 in_valid;
   logic [63:0]          out_data;
   logic [1:0]           out_hdr;
   logic                 out_valid;
   logic [NUM_CH*48-1:0] s_payload_data;
   logic [NUM_CH-1:0]    s_payload_valid;
   logic [NUM_CH-1:0]    s_payload_ready;

   modport master (
      output in_data, in_hdr, in_valid, s_payload_data, s_payload_valid,
      input  out_data, out_hdr, out_valid, s_payload_ready
   );

   modport slave (
      input  in_data, in_hdr, in_valid, s_payload_data, s_payload_valid,
      output out_data, out_hdr, out_valid, s_payload_ready
   );
endinterface

// File: rtl/ipg_multi_ch_inserter.sv
// Replaces idle 64b/66b control blocks with tagged payload blocks taken round-robin
// from per-channel FIFOs, keeping KEEP_IDLE true idles after every terminate block.
module ipg_multi_ch_inserter #(
   parameter int NUM_CH     = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int KEEP_IDLE  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   ipg_multi_ch_inserter_if.slave bus,
   output logic [31:0]           insert_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [47:0]       mem_q [NUM_CH][FIFO_DEPTH];
   logic [AW:0]       wr_ptr_q [NUM_CH];
   logic [AW:0]       wr_ptr_d [NUM_CH];
   logic [AW:0]       rd_ptr_q [NUM_CH];
   logic [AW:0]       rd_ptr_d [NUM_CH];
   logic [NUM_CH-1:0] ready_q, ready_d;
   logic [63:0]       out_data_q, out_data_d;
   logic [1:0]        out_hdr_q, out_hdr_d;
   logic              out_valid_q, out_valid_d;
   logic [31:0]       cnt_q, cnt_d;
   logic [3:0]        gap_q, gap_d;
   logic [CW-1:0]     rr_q, rr_d;

   logic              is_ctrl, is_idle, is_term, found, insert;
   logic [7:0]        blk_type;
   logic [CW-1:0]     cand, grant;
   logic [47:0]       word;
   logic [NUM_CH-1:0] push;

   always_comb begin
      is_ctrl  = (bus.in_hdr == 2'b01);
      blk_type = bus.in_data[7:0];
      is_idle  = is_ctrl && (bus.in_data == 64'h1e);
      is_term  = 1'b0;
      case (blk_type)
         8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1, 8'hff: is_term = is_ctrl;
         default: is_term = 1'b0;
      endcase
   end

   always_comb begin
      found    = 1'b0;
      grant    = '0;
      cand     = '0;
      push     = '0;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      gap_d    = gap_q;
      rr_d     = rr_q;

      for (int unsigned i = 0; i < NUM_CH; i++) begin
         cand = CW'((32'(rr_q) + i) % NUM_CH);
         if (!found && (wr_ptr_q[cand] != rd_ptr_q[cand])) begin
            found = 1'b1;
            grant = cand;
         end
      end

      word   = mem_q[grant][rd_ptr_q[grant][AW-1:0]];
      insert = bus.in_valid && enable && is_idle && (int'(gap_q) >= KEEP_IDLE) && found;

      out_valid_d = bus.in_valid;
      out_hdr_d   = bus.in_hdr;
      out_data_d  = bus.in_data;

      if (insert) begin
         out_hdr_d       = 2'b01;
         out_data_d      = {2'b01, 6'(grant), word, 8'h1e};
         cnt_d           = cnt_q + 32'd1;
         rd_ptr_d[grant] = rd_ptr_q[grant] + 1'b1;
         rr_d            = CW'((32'(grant) + 32'd1) % NUM_CH);
      end

      // Inserted blocks consume an idle slot without counting towards the gap.
      if (bus.in_valid) begin
         if (is_term)
            gap_d = 4'd0;
         else if (is_idle && !insert && (gap_q != 4'hf))
            gap_d = gap_q + 4'd1;
      end

      for (int unsigned c = 0; c < NUM_CH; c++) begin
         push[c] = bus.s_payload_valid[c] && ready_q[c];
         if (push[c])
            wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
         ready_d[c] = !((wr_ptr_d[c][AW] != rd_ptr_d[c][AW]) &&
                        (wr_ptr_d[c][AW-1:0] == rd_ptr_d[c][AW-1:0]));
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (push[c])
            mem_q[c][wr_ptr_q[c][AW-1:0]] <= bus.s_payload_data[48*c +: 48];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            wr_ptr_q[c] <= '0;
            rd_ptr_q[c] <= '0;
         end
         ready_q     <= '1;
         out_data_q  <= '0;
         out_hdr_q   <= 2'b01;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
         gap_q       <= 4'(KEEP_IDLE);
         rr_q        <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         ready_q     <= ready_d;
         out_data_q  <= out_data_d;
         out_hdr_q   <= out_hdr_d;
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
         gap_q       <= gap_d;
         rr_q        <= rr_d;
      end
   end

   always_comb begin
      bus.out_data        = out_data_q;
      bus.out_hdr         = out_hdr_q;
      bus.out_valid       = out_valid_q;
      bus.s_payload_ready = ready_q;
      insert_count        = cnt_q;
   end
endmodule

// File: tb/tb_ipg_multi_ch_inserter.sv
// Directed bench for ipg_multi_ch_inserter: expected output blocks are queued as
// stimulus is driven and popped one cycle later when the registered output appears.
module tb_ipg_multi_ch_inserter;
   localparam int NUM_CH     = 4;
   localparam int FIFO_DEPTH = 8;
   localparam int KEEP_IDLE  = 1;
   localparam logic [63:0] IDLE = 64'h1e;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [31:0] insert_count;

   typedef struct packed {
      logic        v;
      logic [1:0]  h;
      logic [63:0] d;
   } exp_t;

   exp_t sb[$];
   int   checks  = 0;
   int   errors  = 0;
   int   exp_cnt = 0;

   ipg_multi_ch_inserter_if #(.NUM_CH(NUM_CH)) bus ();

   ipg_multi_ch_inserter #(
      .NUM_CH(NUM_CH),
      .FIFO_DEPTH(FIFO_DEPTH),
      .KEEP_IDLE(KEEP_IDLE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .bus(bus),
      .insert_count(insert_count)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ins_blk(input int ch, input logic [47:0] w);
      return {2'b01, 6'(ch), w, 8'h1e};
   endfunction

   function automatic logic [NUM_CH*48-1:0] pdat(input int ch, input logic [47:0] w);
      logic [NUM_CH*48-1:0] p;
      p = '0;
      p[48*ch +: 48] = w;
      return p;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic v, input logic [1:0] h,
                       input logic [63:0] d, input logic [NUM_CH-1:0] pv,
                       input logic [NUM_CH*48-1:0] pd, input logic ev,
                       input logic [1:0] eh, input logic [63:0] ed);
      exp_t e;
      bus.in_valid        = v;
      bus.in_hdr          = h;
      bus.in_data         = d;
      bus.s_payload_valid = pv;
      bus.s_payload_data  = pd;
      sb.push_back('{v: ev, h: eh, d: ed});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, ".valid"}, 64'(bus.out_valid), 64'(e.v));
      if (e.v) begin
         chk({tag, ".hdr"}, 64'(bus.out_hdr), 64'(e.h));
         chk({tag, ".data"}, bus.out_data, e.d);
      end
   endtask

   task automatic pass(input string tag, input logic [1:0] h, input logic [63:0] d);
      step(tag, 1'b1, h, d, '0, '0, 1'b1, h, d);
   endtask

   task automatic idle_ins(input string tag, input int ch, input logic [47:0] w);
      exp_cnt++;
      step(tag, 1'b1, 2'b01, IDLE, '0, '0, 1'b1, 2'b01, ins_blk(ch, w));
   endtask

   task automatic push(input string tag, input logic [NUM_CH-1:0] pv,
                       input logic [NUM_CH*48-1:0] pd);
      step(tag, 1'b0, 2'b01, IDLE, pv, pd, 1'b0, 2'b01, '0);
   endtask

   initial begin
      logic [47:0] w;
      rst = 1'b1;
      enable = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_hdr = 2'b01;
      bus.in_data = IDLE;
      bus.s_payload_valid = '0;
      bus.s_payload_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst.out_hdr", 64'(bus.out_hdr), 64'(2'b01));
      chk("rst.out_data", bus.out_data, 64'h0);
      chk("rst.count", 64'(insert_count), 64'(0));
      chk("rst.ready", 64'(bus.s_payload_ready), 64'(4'hf));
      rst = 1'b0;

      // pass-through with insertion disabled
      pass("pt_data", 2'b10, 64'h1234);
      pass("pt_idle", 2'b01, IDLE);
      chk("pt.count", 64'(insert_count), 64'(0));
      enable = 1'b1;

      // round robin starting from pointer 0
      push("rr_push", 4'b1011, pdat(0, 48'hA00000000000) | pdat(1, 48'hB11111111111) |
                               pdat(3, 48'hC33333333333));
      idle_ins("rr_ch0", 0, 48'hA00000000000);
      idle_ins("rr_ch1", 1, 48'hB11111111111);
      idle_ins("rr_ch3", 3, 48'hC33333333333);
      pass("rr_idle4", 2'b01, IDLE);
      chk("rr.count", 64'(insert_count), 64'(exp_cnt));

      // single insert after terminate with one kept idle
      push("si_push", 4'b0100, pdat(2, 48'hABCDEF012345));
      pass("si_term", 2'b01, 64'h87);
      pass("si_keep", 2'b01, IDLE);
      step("si_ins", 1'b1, 2'b01, IDLE, '0, '0, 1'b1, 2'b01, 64'h42ABCDEF0123451e);
      exp_cnt++;
      chk("si.count", 64'(insert_count), 64'(exp_cnt));

      // 0x1e block with nonzero payload is not idle and pops nothing
      push("ni_push", 4'b0001, pdat(0, 48'hD00D00D00D00));
      pass("ni_block", 2'b01, 64'haddaaddaddadda1e);
      idle_ins("ni_after", 0, 48'hD00D00D00D00);

      // backpressure on ch1
      for (int k = 0; k < FIFO_DEPTH; k++) begin
         chk("bp.ready_pre", 64'(bus.s_payload_ready[1]), 64'(1));
         w = 48'h0B0B00000000 + 48'(k);
         push("bp_push", 4'b0010, pdat(1, w));
      end
      chk("bp.ready_full", 64'(bus.s_payload_ready[1]), 64'(0));
      w = 48'h0B0B00000000 + 48'(FIFO_DEPTH);
      push("bp_held", 4'b0010, pdat(1, w));
      chk("bp.ready_held", 64'(bus.s_payload_ready[1]), 64'(0));
      exp_cnt++;
      step("bp_ins", 1'b1, 2'b01, IDLE, 4'b0010, pdat(1, w), 1'b1, 2'b01,
           ins_blk(1, 48'h0B0B00000000));
      chk("bp.ready_back", 64'(bus.s_payload_ready[1]), 64'(1));
      push("bp_ninth", 4'b0010, pdat(1, w));
      chk("bp.ready_refull", 64'(bus.s_payload_ready[1]), 64'(0));
      for (int k = 1; k <= FIFO_DEPTH; k++)
         idle_ins("bp_drain", 1, 48'h0B0B00000000 + 48'(k));
      pass("bp_empty", 2'b01, IDLE);
      chk("bp.ready_end", 64'(bus.s_payload_ready), 64'(4'hf));
      chk("bp.count", 64'(insert_count), 64'(exp_cnt));

      // invalid cycles inside the gap change nothing
      push("gp_push", 4'b1000, pdat(3, 48'hE3E3E3E3E3E3));
      pass("gp_term", 2'b01, 64'hff);
      step("gp_pause0", 1'b0, 2'b01, IDLE, '0, '0, 1'b0, 2'b01, '0);
      step("gp_pause1", 1'b0, 2'b01, IDLE, '0, '0, 1'b0, 2'b01, '0);
      pass("gp_keep", 2'b01, IDLE);
      idle_ins("gp_ins", 3, 48'hE3E3E3E3E3E3);

      // enable low retains queued words
      push("en_push", 4'b0100, pdat(2, 48'h222222222222));
      enable = 1'b0;
      pass("en_off", 2'b01, IDLE);
      enable = 1'b1;
      idle_ins("en_on", 2, 48'h222222222222);
      chk("en.count", 64'(insert_count), 64'(exp_cnt));

      // reset with words queued
      push("rs_push", 4'b0111, pdat(0, 48'h1) | pdat(1, 48'h2) | pdat(2, 48'h3));
      rst = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_hdr = 2'b01;
      bus.in_data = IDLE;
      bus.s_payload_valid = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_cnt = 0;
      chk("rs.out_valid", 64'(bus.out_valid), 64'(0));
      chk("rs.out_hdr", 64'(bus.out_hdr), 64'(2'b01));
      chk("rs.out_data", bus.out_data, 64'h0);
      chk("rs.ready", 64'(bus.s_payload_ready), 64'(4'hf));
      chk("rs.count", 64'(insert_count), 64'(exp_cnt));
      pass("rs_idle0", 2'b01, IDLE);
      pass("rs_idle1", 2'b01, IDLE);
      chk("rs.count_end", 64'(insert_count), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
